// File: rtl/layer_stage_pkg.sv
// Shared definitions for the fully-connected layer stage: activation codes and
// the control state encoding.
package layer_stage_pkg;

    localparam logic [1:0] ACT_BYPASS = 2'd0;
    localparam logic [1:0] ACT_RELU   = 2'd1;
    localparam logic [1:0] ACT_HSIG   = 2'd2;

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_FINISH = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

endpackage

// File: rtl/layer_stage_if.sv
// Valid/ready streams of the layer stage: serial input samples in, one
// activated neuron result per output beat.
interface layer_stage_if #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_index;
    logic                     out_last;

    modport master (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_index, out_last
    );

    modport slave (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/layer_stage_act.sv
// Result path for one accumulator: rescale out of the product Q format,
// saturate to the data width, then apply the selected activation.
module layer_stage_act
    import layer_stage_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int FRAC_W = 8,
    parameter int ACC_W  = 40
) (
    input  logic signed [ACC_W-1:0]  acc,
    input  logic [1:0]               mode,
    output logic signed [DATA_W-1:0] result
);
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] HALF = DATA_W'(1 << (FRAC_W-1));
    localparam logic signed [DATA_W-1:0] ONE  = DATA_W'(1 << FRAC_W);

    logic signed [ACC_W-1:0]  scaled;
    logic signed [DATA_W-1:0] sat;
    logic signed [DATA_W-1:0] hs;

    // NOTE: every output of a combinational block is given a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        scaled = acc >>> FRAC_W;
        if (scaled > SAT_MAX)
            sat = SAT_MAX[DATA_W-1:0];
        else if (scaled < SAT_MIN)
            sat = SAT_MIN[DATA_W-1:0];
        else
            sat = scaled[DATA_W-1:0];

        // Hard sigmoid: slope 1/4 centred on 0.5, clamped to [0, 1].
        hs     = (sat >>> 2) + HALF;
        result = sat;
        case (mode)
            ACT_RELU: result = sat[DATA_W-1] ? '0 : sat;
            ACT_HSIG: begin
                if (hs < 0)
                    result = '0;
                else if (hs > ONE)
                    result = ONE;
                else
                    result = hs;
            end
            default: result = sat;
        endcase
    end
endmodule

// File: rtl/layer_stage.sv
// Fully-connected layer stage: N_NEURON MAC neurons share one serial input
// stream, then their activated results are serialised onto the output stream.
module layer_stage
    import layer_stage_pkg::*;
#(
    parameter int N_NEURON = 6,
    parameter int N_INPUT  = 16,
    parameter int DATA_W   = 16,
    parameter int FRAC_W   = 8,
    parameter int ACC_W    = 40
) (
    input  logic                         clk,
    input  logic                         reset,
    layer_stage_if.slave                 bus,
    input  logic [N_NEURON*DATA_W-1:0]   taps,
    input  logic [N_NEURON*DATA_W-1:0]   bias,
    input  logic [1:0]                   mode,
    output logic                         len_err
);
    localparam int IDX_W  = (N_NEURON > 1) ? $clog2(N_NEURON) : 1;
    localparam int CNT_W  = $clog2(N_INPUT + 1);
    localparam int PROD_W = 2 * DATA_W;

    state_t                   state, state_next;
    logic [CNT_W-1:0]         count;
    logic [1:0]               mode_q;
    logic signed [ACC_W-1:0]  acc [N_NEURON];

    logic                     out_valid, out_last;
    logic signed [DATA_W-1:0] out_data;
    logic [IDX_W-1:0]         out_index;

    logic                     in_ready, accept, is_nth, vec_end, out_fire, is_last_idx;
    logic [IDX_W-1:0]         idx_next, sel_idx;
    logic signed [ACC_W-1:0]  act_in;
    logic signed [DATA_W-1:0] act_result;

    logic signed [PROD_W-1:0] din_w;
    logic signed [PROD_W-1:0] tap_w    [N_NEURON];
    logic signed [PROD_W-1:0] prod     [N_NEURON];
    logic signed [ACC_W-1:0]  prod_ext [N_NEURON];
    logic signed [ACC_W-1:0]  bias_ext [N_NEURON];

    assign in_ready    = (state == ST_ACCUM);
    assign accept      = bus.in_valid && in_ready;
    assign is_nth      = (count == CNT_W'(N_INPUT - 1));
    assign vec_end     = accept && (bus.in_last || is_nth);
    assign out_fire    = out_valid && bus.out_ready;
    assign is_last_idx = (out_index == IDX_W'(N_NEURON - 1));
    assign idx_next    = out_index + IDX_W'(1);

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_index = out_index;
    assign bus.out_last  = out_last;

    // Full-precision signed products and Q-aligned biases, widened to ACC_W.
    always_comb begin
        din_w = {{(PROD_W-DATA_W){bus.in_data[DATA_W-1]}}, bus.in_data};
        for (int i = 0; i < N_NEURON; i++) begin
            tap_w[i]    = {{(PROD_W-DATA_W){taps[i*DATA_W+DATA_W-1]}}, taps[i*DATA_W +: DATA_W]};
            prod[i]     = din_w * tap_w[i];
            prod_ext[i] = {{(ACC_W-PROD_W){prod[i][PROD_W-1]}}, prod[i]};
            bias_ext[i] = {{(ACC_W-DATA_W){bias[i*DATA_W+DATA_W-1]}}, bias[i*DATA_W +: DATA_W]} <<< FRAC_W;
        end
    end

    always_comb begin
        state_next = state;
        sel_idx    = '0;
        case (state)
            ST_ACCUM:  if (vec_end) state_next = ST_FINISH;
            ST_FINISH: state_next = ST_DRAIN;
            ST_DRAIN: begin
                // Present the next neuron so it loads on the same handshake edge.
                if (!is_last_idx) sel_idx = idx_next;
                if (out_fire && is_last_idx) state_next = ST_ACCUM;
            end
            default:   state_next = ST_ACCUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= ST_ACCUM;
            count   <= '0;
            mode_q  <= ACT_BYPASS;
            len_err <= 1'b0;
        end else begin
            state   <= state_next;
            len_err <= vec_end && (bus.in_last != is_nth);
            if (accept) begin
                if (count == '0) mode_q <= mode;
                count <= vec_end ? '0 : count + CNT_W'(1);
            end
        end
    end

    // NOTE: the accumulator array is reset explicitly because a reset mid-vector must discard the partial sums, not just the control state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < N_NEURON; i++) acc[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < N_NEURON; i++) begin
                if (count == '0)
                    acc[i] <= bias_ext[i] + prod_ext[i];
                else
                    acc[i] <= acc[i] + prod_ext[i];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_index <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                ST_FINISH: begin
                    out_valid <= 1'b1;
                    out_data  <= act_result;
                    out_index <= '0;
                    out_last  <= (N_NEURON == 1);
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (is_last_idx) begin
                            out_valid <= 1'b0;
                        end else begin
                            out_data  <= act_result;
                            out_index <= idx_next;
                            out_last  <= (idx_next == IDX_W'(N_NEURON - 1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign act_in = acc[sel_idx];

    layer_stage_act #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_act (
        .acc    (act_in),
        .mode   (mode_q),
        .result (act_result)
    );
endmodule

// File: tb/tb_layer_stage.sv
// Directed bench for layer_stage with two neurons and three-beat vectors:
// table-driven vectors plus back-pressure and reset sequences.
module tb_layer_stage;
    import layer_stage_pkg::*;

    localparam int N_NEURON = 2;
    localparam int N_INPUT  = 3;
    localparam int DATA_W   = 16;
    localparam int FRAC_W   = 8;
    localparam int ACC_W    = 40;
    localparam int IDX_W    = 1;

    typedef struct packed {
        logic signed [15:0] d0, d1, d2;
        logic signed [15:0] tap0, tap1;
        logic signed [15:0] bias0, bias1;
        logic [1:0]         mode;
        logic [1:0]         n_beats;
        logic               last_flag;
        logic signed [15:0] exp0, exp1;
        logic               exp_len_err;
    } vec_t;

    logic                       clk = 1'b0;
    logic                       reset;
    logic [N_NEURON*DATA_W-1:0] taps, bias;
    logic [1:0]                 mode;
    logic                       len_err;
    int                         checks = 0;
    int                         failures = 0;
    vec_t                       vecs [8];
    vec_t                       base;

    layer_stage_if #(.DATA_W(DATA_W), .IDX_W(IDX_W)) bus ();

    layer_stage #(
        .N_NEURON (N_NEURON),
        .N_INPUT  (N_INPUT),
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .ACC_W    (ACC_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus.slave),
        .taps    (taps),
        .bias    (bias),
        .mode    (mode),
        .len_err (len_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int d0, d1, d2, t0, t1, b0, b1, m, nb, lf, e0, e1, le);
        vec_t v;
        v.d0 = 16'(d0); v.d1 = 16'(d1); v.d2 = 16'(d2);
        v.tap0 = 16'(t0); v.tap1 = 16'(t1);
        v.bias0 = 16'(b0); v.bias1 = 16'(b1);
        v.mode = 2'(m); v.n_beats = 2'(nb); v.last_flag = 1'(lf);
        v.exp0 = 16'(e0); v.exp1 = 16'(e1); v.exp_len_err = 1'(le);
        return v;
    endfunction

    task automatic drive_beat(input vec_t v, input int b);
        int nb;
        nb = int'(v.n_beats);
        @(negedge clk);
        check("in_ready_before_beat", bus.in_ready, 1);
        bus.in_valid = 1'b1;
        bus.in_data  = (b == 0) ? v.d0 : (b == 1) ? v.d1 : v.d2;
        bus.in_last  = v.last_flag && (b == nb - 1);
        taps = {v.tap1, v.tap0};
        bias = {v.bias1, v.bias0};
        mode = v.mode;
    endtask

    // Leaves the bench at the falling edge of the FINISH cycle.
    task automatic drive_vector(input vec_t v);
        for (int b = 0; b < int'(v.n_beats); b++) drive_beat(v, b);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic check_finish(input logic exp_len_err);
        check("len_err_finish", len_err, exp_len_err);
        check("out_valid_finish", bus.out_valid, 0);
        check("in_ready_finish", bus.in_ready, 0);
    endtask

    task automatic check_drain(input logic signed [15:0] e0, input logic signed [15:0] e1);
        @(negedge clk);
        check("out_valid_beat0", bus.out_valid, 1);
        check("out_data_beat0", bus.out_data, e0);
        check("out_index_beat0", bus.out_index, 0);
        check("out_last_beat0", bus.out_last, 0);
        check("len_err_cleared", len_err, 0);
        @(negedge clk);
        check("out_valid_beat1", bus.out_valid, 1);
        check("out_data_beat1", bus.out_data, e1);
        check("out_index_beat1", bus.out_index, 1);
        check("out_last_beat1", bus.out_last, 1);
        @(negedge clk);
        check("out_valid_done", bus.out_valid, 0);
        check("in_ready_done", bus.in_ready, 1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_out_valid"}, bus.out_valid, 0);
        check({tag, "_out_data"}, bus.out_data, 0);
        check({tag, "_out_index"}, bus.out_index, 0);
        check({tag, "_out_last"}, bus.out_last, 0);
        check({tag, "_len_err"}, len_err, 0);
        check({tag, "_in_ready"}, bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;
        taps  = '0;
        bias  = '0;
        mode  = 2'd0;
        reset = 1'b0;

        @(negedge clk);
        check_reset_state("reset");
        @(negedge clk);
        reset = 1'b1;

        //           d0      d1      d2     t0   t1   b0   b1  m nb lf  e0      e1     le
        vecs[0] = mk(256,    512,    -256,  128, 256, 64, -768, 0, 3, 1, 320,   -256,   0);
        vecs[1] = mk(256,    512,    -256,  128, 256, 64, -768, 1, 3, 1, 320,   0,      0);
        vecs[2] = mk(256,    512,    -256,  128, 256, 64, -768, 2, 3, 1, 208,   64,     0);
        vecs[3] = mk(256,    512,    -256,  128, 256, 64, -768, 3, 3, 1, 320,   -256,   0);
        vecs[4] = mk(32767,  32767,  32767, 256, 256, 0,  0,    0, 3, 1, 32767, 32767,  0);
        vecs[5] = mk(-32768, -32768, -32768,256, 256, 0,  0,    0, 3, 1, -32768,-32768, 0);
        vecs[6] = mk(256,    512,    0,     128, 256, 64, -768, 0, 2, 1, 448,   0,      1);
        vecs[7] = mk(256,    512,    -256,  128, 256, 64, -768, 0, 3, 0, 320,   -256,   1);
        base = vecs[0];

        for (int k = 0; k < 8; k++) begin
            drive_vector(vecs[k]);
            check_finish(vecs[k].exp_len_err);
            check_drain(vecs[k].exp0, vecs[k].exp1);
        end

        // Back-pressure: first result must hold until the downstream accepts it.
        bus.out_ready = 1'b0;
        drive_vector(base);
        check_finish(0);
        @(negedge clk);
        check("bp_out_valid", bus.out_valid, 1);
        check("bp_out_data_first", bus.out_data, 320);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_data", bus.out_data, 320);
            check("bp_hold_index", bus.out_index, 0);
            check("bp_hold_valid", bus.out_valid, 1);
            check("bp_in_ready_low", bus.in_ready, 0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_out_data_second", bus.out_data, -256);
        check("bp_out_index_second", bus.out_index, 1);
        check("bp_out_last_second", bus.out_last, 1);
        @(negedge clk);
        check("bp_out_valid_done", bus.out_valid, 0);
        check("bp_in_ready_done", bus.in_ready, 1);

        // Reset after two beats discards the partial vector.
        drive_beat(base, 0);
        drive_beat(base, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        reset = 1'b0;
        #1;
        check_reset_state("rst_mid_vec");
        @(negedge clk);
        reset = 1'b1;
        drive_vector(base);
        check_finish(0);
        check_drain(320, -256);

        // Reset while a result is pending discards the remaining beats.
        bus.out_ready = 1'b0;
        drive_vector(base);
        check_finish(0);
        @(negedge clk);
        check("rst_drain_pending", bus.out_valid, 1);
        reset = 1'b0;
        #1;
        check_reset_state("rst_mid_drain");
        @(negedge clk);
        reset = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_no_stale_beat", bus.out_valid, 0);
        end
        drive_vector(base);
        check_finish(0);
        check_drain(320, -256);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/layer_stage.md
# layer_stage

Parametrised fully-connected layer stage: N_NEURON fixed-point multiply-accumulate neurons share one serial input stream, each neuron applying its own per-beat tap, seeded with a per-neuron bias. At vector end the accumulators are scaled, saturated, passed through a runtime-selectable activation and serialised onto a valid/ready output stream, one neuron per beat. It sits between consecutive layers in the network datapath and generalises the fixed six-neuron float stage with back-pressure, length checking and activation modes.

## Interface
- N_NEURON, 6: neurons per stage (≥1).
- N_INPUT, 16: nominal input vector length (≥1).
- DATA_W, 16: signed two's-complement data/tap/bias width.
- FRAC_W, 8: fractional bits of data, taps and bias (Q format, FRAC_W < DATA_W-2).
- ACC_W, 40: signed accumulator width (≥ 2*DATA_W + clog2(N_INPUT) + 1).
- clk  in  1  clock; all state on rising edge.
- reset  in  1  asynchronous, active-low; clears all state immediately.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage accepts input; a beat is accepted when in_valid && in_ready.
- in_data  in  DATA_W  input sample.
- in_last  in  1  final beat of the vector.
- taps  in  N_NEURON*DATA_W  per-neuron weight for the current beat; neuron i at [i*DATA_W +: DATA_W].
- bias  in  N_NEURON*DATA_W  per-neuron bias, same packing; sampled on the first beat.
- mode  in  2  activation: 0 bypass, 1 ReLU, 2 hard sigmoid, 3 reserved (treated as bypass); sampled on the first beat.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts output.
- out_data  out  DATA_W  activated neuron result.
- out_index  out  clog2(N_NEURON) (min 1)  neuron number of out_data.
- out_last  out  1  high with neuron N_NEURON-1.
- len_err  out  1  one-cycle pulse on a vector-length violation.

## Operation
- States: ACCUM, FINISH, DRAIN. Reset: state ACCUM, beat count 0, accumulators 0, out_valid 0, out_data 0, out_index 0, out_last 0, len_err 0; in_ready=1.
- ACCUM: in_ready=1. First accepted beat of a vector (count 0): acc[i] = (bias[i] sign-extended << FRAC_W) + in_data*taps[i]; mode latched. Later beats: acc[i] += in_data*taps[i]. Products full 2*DATA_W signed, sign-extended to ACC_W; accumulation wraps in ACC_W (no saturation inside).
- Vector ends on the accepted beat that carries in_last or is beat N_INPUT, whichever comes first; then state → FINISH, count → 0. len_err pulses the next cycle if in_last came before beat N_INPUT or beat N_INPUT lacked in_last; the vector is processed regardless.
- FINISH (one cycle, in_ready=0): register result of neuron 0 into out_data, out_index=0, out_valid=1, out_last=(N_NEURON==1); state → DRAIN.
- DRAIN (in_ready=0): out_data/out_index/out_last held stable while out_valid && !out_ready. On handshake with index < N_NEURON-1, load neuron index+1 the same edge (back-to-back beats). On handshake of the last neuron: out_valid=0, state → ACCUM.
- Result path per neuron: x = acc >>> FRAC_W (arithmetic, rounds toward −∞); saturate to [−2^(DATA_W-1), 2^(DATA_W-1)−1]; then bypass: x; ReLU: max(x,0); hard sigmoid: clamp((x >>> 2) + 2^(FRAC_W-1), 0, 2^FRAC_W).
- Reset mid-vector or mid-drain: partial vector and pending outputs discarded; no output beat emitted afterwards.

## Timing
- Last input accepted in cycle T → out_valid high in cycle T+2 (T+1 is FINISH).
- With out_ready held high, N_NEURON output beats in consecutive cycles T+2 … T+N_NEURON+1; in_ready returns high the cycle after the final handshake.
- Minimum vector period: N_INPUT + N_NEURON + 1 cycles.
- in_ready is a function of state only (no combinational path from out_ready).

## Structure
- Package layer_stage_pkg: mode encoding constants (ACT_BYPASS, ACT_RELU, ACT_HSIG), state enum.
- Sub-module layer_stage_act: combinational scale/saturate/activate of one ACC_W value, parametrised by DATA_W, FRAC_W, ACC_W; instantiated once on the mux-selected accumulator.

## Test plan
- N_NEURON=2, N_INPUT=3, defaults otherwise; inputs 256, 512, −256 (last on beat 3); taps n0 128,128,128, n1 256,256,256; bias n0 64, n1 −768; mode 0 → outputs 320 (idx0), −256 (idx1, out_last), len_err never pulses, first out_valid 2 cycles after last beat.
- Same stimulus, mode 1 → 320, 0; mode 2 → 208, 64.
- Inputs 32767 ×3, taps 256 both, bias 0, mode 0 → both outputs 32767 (saturated); inputs −32768 ×3 → −32768.
- out_ready low 5 cycles during DRAIN → out_data/out_index stable, in_ready low, no beat lost; then 320, −256 in order.
- in_last on beat 2 → vector of 2 processed, len_err one-cycle pulse; 3 beats without in_last → processed, len_err pulses.
- reset asserted after beat 2 and again with out_valid high → all outputs 0 immediately; next full vector yields 320, −256.
